// File: rtl/mem_uart_streamer.sv
// Streams a run of 16-bit words from the result RAM to the UART transmitter,
// two bytes per word (low byte first), one tx_en/tx_done handshake per byte.
module mem_uart_streamer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_en,
  input  logic              tx_done,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W+1:0] bytes_sent
);

  typedef enum logic [2:0] {
    IDLE, RD, CAPT, TX_LO, WAIT_LO, TX_HI, WAIT_HI, FIN
  } state_t;

  localparam logic [ADDR_W:0]   IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W+1:0] CNT_ONE = {{(ADDR_W+1){1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   word_idx;
  logic [ADDR_W:0]   idx_nxt;
  logic [7:0]        hi_byte;

  assign idx_nxt = word_idx + IDX_ONE;

  // rd_en/tx_en are set on the edge that enters RD/TX_* so they line up with
  // the state; done/busy are updated from FIN and so appear one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      word_idx   <= '0;
      hi_byte    <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      tx_data    <= '0;
      tx_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bytes_sent <= '0;
    end else begin
      rd_en <= 1'b0;
      tx_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q     <= base_addr;
            len_q      <= len;
            word_idx   <= '0;
            bytes_sent <= '0;
            busy       <= 1'b1;
            if (len != '0) begin
              state   <= RD;
              rd_en   <= 1'b1;
              rd_addr <= base_addr;
            end else begin
              state <= FIN;
            end
          end
        end
        RD: state <= CAPT;
        CAPT: begin
          hi_byte <= rd_data[15:8];
          tx_data <= rd_data[7:0];
          tx_en   <= 1'b1;
          state   <= TX_LO;
        end
        TX_LO: state <= WAIT_LO;
        WAIT_LO: begin
          if (tx_done) begin
            bytes_sent <= bytes_sent + CNT_ONE;
            tx_data    <= hi_byte;
            tx_en      <= 1'b1;
            state      <= TX_HI;
          end
        end
        TX_HI: state <= WAIT_HI;
        WAIT_HI: begin
          if (tx_done) begin
            bytes_sent <= bytes_sent + CNT_ONE;
            word_idx   <= idx_nxt;
            if (idx_nxt == len_q) begin
              state <= FIN;
            end else begin
              state   <= RD;
              rd_en   <= 1'b1;
              rd_addr <= base_q + idx_nxt[ADDR_W-1:0];
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_uart_streamer.sv
// Scoreboard bench for mem_uart_streamer: stimulus pushes expected reads, bytes
// and done counts; a negedge monitor pops and compares as the DUT emits them.
module tb_mem_uart_streamer;
  localparam int ADDR_W = 8;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  base_addr;
  logic [8:0]  len;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_en, tx_done, busy, done;
  logic [9:0]  bytes_sent;

  always #5 clk = ~clk;

  mem_uart_streamer #(.ADDR_W(ADDR_W), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_en(tx_en), .tx_done(tx_done),
    .busy(busy), .done(done), .bytes_sent(bytes_sent)
  );

  logic [15:0] mem [256];
  logic [7:0]  exp_addr [$];
  logic [7:0]  exp_bytes [$];
  int          exp_done [$];
  int n_vec = 0, n_err = 0;
  int done_cnt = 0, tx_cnt = 0;
  int uart_delay = 5;
  bit stray = 1'b0, idle_poke = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory returns data only in the cycle after rd_en (garbage otherwise);
  // UART answers each tx_en with tx_done uart_delay cycles later, and can
  // inject stray tx_done pulses in RD, CAPT, TX_* cycles or on request.
  initial begin
    int cnt = 0;
    bit ren_d = 1'b0, capt_now;
    logic [7:0] a_d = '0;
    tx_done = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      capt_now = ren_d;
      rd_data  = capt_now ? mem[a_d] : 16'($urandom);
      ren_d    = (rd_en === 1'b1);
      a_d      = rd_addr;
      tx_done  = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) tx_done = 1'b1;
      end
      if (tx_en === 1'b1) cnt = uart_delay;
      if (stray && (rd_en === 1'b1 || capt_now || tx_en === 1'b1)) tx_done = 1'b1;
      if (idle_poke) tx_done = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (rd_en === 1'b1) begin
        if (exp_addr.size() == 0) check("unexpected_rd_en", 1, 0);
        else check("rd_addr", rd_addr, exp_addr.pop_front());
      end
      if (tx_en === 1'b1) begin
        tx_cnt++;
        check("busy_during_tx", busy, 1);
        if (exp_bytes.size() == 0) check("unexpected_tx_en", 1, 0);
        else check("tx_byte", tx_data, exp_bytes.pop_front());
      end
      if (done === 1'b1) begin
        done_cnt++;
        check("busy_low_at_done", busy, 0);
        if (exp_done.size() == 0) check("unexpected_done", 1, 0);
        else check("bytes_sent_at_done", bytes_sent, exp_done.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_xfer(int b, int l);
    logic [7:0] a;
    for (int i = 0; i < l; i++) begin
      a = 8'((b + i) % 256);
      exp_addr.push_back(a);
      exp_bytes.push_back(mem[a][7:0]);
      exp_bytes.push_back(mem[a][15:8]);
    end
    exp_done.push_back(2 * l);
  endtask

  task automatic wait_done(int budget);
    int c0 = done_cnt;
    for (int k = 0; k < budget && done_cnt == c0; k++) tick();
    check("done_seen_in_budget", done_cnt != c0, 1);
  endtask

  task automatic run_xfer(int b, int l);
    push_xfer(b, l);
    base_addr = 8'(b);
    len       = 9'(l);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    base_addr = 8'($urandom);
    len       = 9'($urandom);
    wait_done(l * (6 + 2 * uart_delay) + 20);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
  endtask

  initial begin
    int b, l, c0;
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    fill_random();
    repeat (3) tick();
    check("reset_outputs", {rd_en, rd_addr, tx_data, tx_en, busy, done, bytes_sent}, 0);
    rst = 1'b0;
    tick();

    // Basic two-word transfer
    mem[0] = 16'h1234; mem[1] = 16'hABCD; uart_delay = 5;
    run_xfer(0, 2);
    check("basic_bytes_sent", bytes_sent, 4);
    tick();
    check("done_single_pulse", done, 0);
    check("basic_rd_all_seen", exp_addr.size(), 0);

    // Zero-length transfer
    push_xfer(7, 0);
    base_addr = 8'd7; len = '0; start = 1'b1;
    tick();
    start = 1'b0;
    check("len0_busy_c1", {busy, done}, 2'b10);
    tick();
    check("len0_done_c2", {busy, done}, 2'b01);
    tick();
    check("len0_idle_c3", {busy, done}, 2'b00);
    check("len0_bytes_sent", bytes_sent, 0);

    // Address wrap past the top
    fill_random();
    run_xfer(8'hFF, 2);
    check("wrap_bytes_sent", bytes_sent, 4);

    // start held high through a transfer, stray tx_done pulses, inputs changed after latch
    fill_random(); uart_delay = 3;
    idle_poke = 1'b1; tick(); idle_poke = 1'b0; tick();
    check("idle_poke_ignored", {busy, bytes_sent}, {1'b0, 10'd4});
    stray = 1'b1;
    b = $urandom_range(0, 255); l = $urandom_range(1, 5);
    push_xfer(b, l);
    base_addr = 8'(b); len = 9'(l); start = 1'b1;
    tick();
    b = $urandom_range(0, 255); l = $urandom_range(1, 5);
    base_addr = 8'(b); len = 9'(l);
    wait_done(200);
    push_xfer(b, l);
    tick();
    start = 1'b0;
    check("restart_from_idle_busy", busy, 1);
    wait_done(200);
    check("held_start_bytes_sent", bytes_sent, 2 * l);
    stray = 1'b0;
    repeat (4) tick();
    check("no_third_transfer", busy, 0);

    // Reset during WAIT_HI of word 0
    fill_random(); uart_delay = 5;
    push_xfer(20, 3);
    base_addr = 8'd20; len = 9'd3; start = 1'b1;
    c0 = tx_cnt;
    tick();
    start = 1'b0;
    for (int k = 0; k < 40 && tx_cnt < c0 + 2; k++) tick();
    check("abort_reached_tx_hi", tx_cnt, c0 + 2);
    tick();
    rst = 1'b1;
    tick();
    check("abort_reset_outputs", {rd_en, rd_addr, tx_data, tx_en, busy, done, bytes_sent}, 0);
    exp_addr.delete(); exp_bytes.delete(); exp_done.delete();
    rst = 1'b0;
    repeat (10) tick();
    check("abort_stale_tx_done_ignored", {busy, bytes_sent}, 0);
    run_xfer(33, 1);
    check("after_abort_bytes_sent", bytes_sent, 2);

    // Full-depth transfer
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101);
    uart_delay = 1;
    run_xfer(0, 256);
    check("full_bytes_sent", bytes_sent, 512);

    // Randomized transfers
    for (int t = 0; t < 30; t++) begin
      fill_random();
      uart_delay = $urandom_range(1, 6);
      stray = 1'($urandom_range(0, 1));
      run_xfer($urandom_range(0, 255), $urandom_range(0, 24));
      tick();
    end
    stray = 1'b0;
    repeat (5) tick();

    check("left_exp_addr", exp_addr.size(), 0);
    check("left_exp_bytes", exp_bytes.size(), 0);
    check("left_exp_done", exp_done.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_uart_streamer.md
Name: mem_uart_streamer

Overview:
Transmit-side counterpart to the UART receive path that fills result memory. On a start pulse, reads a run of 16-bit words from the result RAM and sends each word to the UART transmitter as two bytes, low byte first, with one tx_en/tx_done handshake per byte. Sits between the result memory read port and the UART TxData/TxEn/TxDone interface.

Parameters:
ADDR_W, 8, memory word-address width
DATA_W, 16, memory word width; fixed at 16 (two bytes per word)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle request to begin a transfer; sampled only in IDLE
base_addr  in  ADDR_W  first word address; latched on accepted start
len  in  ADDR_W+1  number of words to send, 0..2^ADDR_W; latched on accepted start
rd_en  out  1  memory read strobe
rd_addr  out  ADDR_W  memory word address
rd_data  in  16  memory read data, valid exactly 1 cycle after rd_en
tx_data  out  8  byte to the UART transmitter
tx_en  out  1  one-cycle pulse: UART loads tx_data
tx_done  in  1  one-cycle pulse from UART when the byte has finished shifting out
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at end of transfer
bytes_sent  out  ADDR_W+2  bytes completed in the current or last transfer

Behaviour:
- Reset (sync, active-high, highest priority): state=IDLE; rd_en=0, rd_addr=0, tx_data=0, tx_en=0, busy=0, done=0, bytes_sent=0; latched base/len cleared. Reset mid-transfer aborts immediately; the in-flight UART byte is not tracked.
- States: IDLE, RD, CAPT, TX_LO, WAIT_LO, TX_HI, WAIT_HI, FIN.
- IDLE: start=1 -> latch base_addr and len, clear word_idx and bytes_sent, go RD (len>0) or FIN (len=0). busy=1 from the next cycle.
- RD: rd_en=1, rd_addr=(base+word_idx) mod 2^ADDR_W (wraps past the top address). -> CAPT.
- CAPT: register rd_data into the 16-bit word buffer. -> TX_LO.
- TX_LO: tx_data=buf[7:0], tx_en=1 for exactly this cycle. -> WAIT_LO.
- WAIT_LO: tx_en=0, tx_data held; on tx_done: bytes_sent+=1, -> TX_HI.
- TX_HI / WAIT_HI: same pattern with buf[15:8]. On tx_done: bytes_sent+=1, word_idx+=1; -> FIN if word_idx+1==len, else RD.
- FIN: done=1 for one cycle, busy=0 in the same cycle; -> IDLE. bytes_sent holds until the next accepted start or reset.
- tx_done counts only in WAIT_LO/WAIT_HI. tx_done in any other state, including the same cycle as tx_en, is ignored.
- start while not in IDLE is ignored. base_addr and len changes after latch have no effect.
- Minimum latency per word: 6 cycles plus the two UART byte times.
- rd_en is high only in RD, so there is exactly one read per word. rd_addr holds its last value when not in RD.
- word_idx is ADDR_W+1 bits so len=2^ADDR_W completes without aliasing.

Test Plan:
- mem[0]=0x1234, mem[1]=0xABCD, base=0, len=2, tx_done returned 5 cycles after each tx_en -> tx_en bytes in order 0x34,0x12,0xCD,0xAB; done pulses once, 1 cycle after the 4th tx_done; bytes_sent=4; rd_en asserted exactly twice.
- len=0, start -> no rd_en and no tx_en; done high exactly 1 cycle, 2 cycles after start; bytes_sent=0; busy high for 1 cycle.
- base=0xFF, len=2 (ADDR_W=8) -> rd_addr sequence 0xFF then 0x00.
- start held high for the whole transfer, plus tx_done pulses injected in IDLE, RD and CAPT -> exactly one transfer; stray tx_done does not advance state or bytes_sent; a second transfer begins only on start sampled in IDLE after done.
- rst asserted while in WAIT_HI of word 0 -> next cycle all outputs at reset values, state IDLE; a fresh start with len=1 sends 2 bytes correctly.
- len=256, base=0, mem[i]=i*0x0101 -> 512 bytes, each byte of word i equals i; bytes_sent=512; single done pulse.
